fpu_issue_scheduler: RTL and testbench
======================================

Name: fpu_issue_scheduler

Overview:
- In-order issue scheduler for the FPU execution units: adder (ADD/SUB, pipelined), multiplier (pipelined) and divider (iterative, not pipelined).
- Accepts one op per cycle over a valid/ready handshake and drives one-hot start flags to the units, bit-ordered ADD=0, SUB=1, MUL=2, DIV=3.
- Guarantees that no two results reach the single shared writeback port in the same cycle, and that the divider is never restarted while busy.
- Sits between the op decode/queue stage and the execution units; its writeback outputs tag the returning result.

Parameters:
- ADD_LAT, 2, adder latency in cycles (shared by ADD and SUB); legal 1..16
- MUL_LAT, 3, multiplier latency in cycles; legal 1..16
- DIV_LAT, 6, divider latency in cycles, and the divider occupancy; legal 1..16
- TAG_W, 4, width of the op tag carried with each op

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  op offered
- in_ready  out  1  op accepted this cycle when in_valid is also high
- in_op  in  2  opcode: 0=ADD, 1=SUB, 2=MUL, 3=DIV
- in_tag  in  TAG_W  tag carried with the op
- issue_flags  out  4  one-hot unit start; bit index equals opcode
- issue_tag  out  TAG_W  tag for the unit being started
- wb_valid  out  1  result returns this cycle
- wb_op  out  2  opcode of the returning result
- wb_tag  out  TAG_W  tag of the returning result
- div_busy  out  1  divider occupied
- in_flight  out  5  number of ops issued whose writeback has not yet occurred
- idle  out  1  in_flight==0 and div_busy==0

Behaviour:
- One clock domain (clk). rst is synchronous and active-high.
- Handshake (HS): an HS occurs in cycle t when in_valid=1 and in_ready=1. LAT(op) is ADD_LAT for ADD/SUB, MUL_LAT for MUL, DIV_LAT for DIV.
- in_ready is combinational from in_op and registered state. in_ready=1 only when all of the following hold:
  - rst=0;
  - writeback slot t+LAT(in_op) is not already reserved;
  - if in_op=DIV, the divider is free in cycle t.
- in_ready must not depend on in_valid.
- issue_flags and issue_tag are combinational:
  - on an HS, issue_flags has exactly bit in_op set and issue_tag=in_tag;
  - otherwise issue_flags=0 and issue_tag=0.
- Reservation table: a shift register of 16 entries, each {valid, op, tag}, indexed by cycles-until-writeback.
  - Every cycle it shifts one position toward the output end.
  - On an HS the entry at distance LAT(op) is written.
  - The entry reaching distance 0 drives wb_valid/wb_op/wb_tag, which are registered outputs.
- Writeback timing: an HS in cycle t gives wb_valid=1 in exactly cycle t+LAT(op), for one cycle, carrying that op's opcode and tag. When wb_valid=0, wb_op=0 and wb_tag=0.
- Results return in writeback-slot order, not issue order. A later MUL with an earlier slot may overtake a DIV.
- Divider occupancy:
  - A DIV HS in cycle t makes div_busy=1 in cycles t+1 .. t+DIV_LAT-1.
  - A new DIV may HS in cycle t+DIV_LAT, the same cycle as the first DIV's writeback.
  - With DIV_LAT=1, div_busy stays 0.
  - Non-DIV ops are unaffected by div_busy.
- in_flight: +1 on an HS, -1 on wb_valid, unchanged when both occur in the same cycle. It never exceeds 16.
- Head-of-line: a blocked op stalls all later ops (strict in-order). The block never reorders its input.
- Reset:
  - In any cycle with rst=1, the next state clears the table, div_busy, in_flight and the wb_* outputs.
  - Ops already issued are discarded: no wb_valid for them after reset.
  - in_ready=0 and issue_flags=0 while rst=1.
- Reset values: wb_valid=0, wb_op=0, wb_tag=0, div_busy=0, in_flight=0, idle=1, in_ready=0 during rst, issue_flags=0, issue_tag=0.
- Illegal parameter values (any LAT outside 1..16) trigger a simulation-time elaboration assertion.

Decomposition:
- Shared package fpu_pkg holds:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3;
  - typedef fpu_op_t (2-bit);
  - typedef wb_slot_t {valid, op, tag};
  - MAX_LAT=16.
- Sub-module wb_reservation_table: shift register, slot-free lookup by distance, and write at distance. The scheduler keeps the handshake, divider occupancy, in_flight and flag decode.

Test Plan (default parameters; cycles counted from the first HS = cycle 0):
- Reset: rst=1 for 2 cycles with in_valid=1, in_op=ADD → in_ready=0, issue_flags=0, wb_valid=0, idle=1, in_flight=0.
- Streaming ADDs: tags 1,2,3 in cycles 0,1,2 → issue_flags=0001 each cycle; wb_valid with tags 1,2,3 in cycles 2,3,4, wb_op=0; in_flight peaks at 2.
- Writeback collision: MUL tag 5 in cycle 0, then ADD tag 6 offered from cycle 1 → in_ready=0 in cycle 1 (slot 3 taken); ADD accepted in cycle 2; wb tag 5 in cycle 3, tag 6 in cycle 4.
- Divider hazard: DIV tag 7 in cycle 0, DIV tag 8 offered from cycle 1 → div_busy=1 in cycles 1-5; in_ready=0 in cycles 1-5; tag 8 HS in cycle 6; wb tag 7 in cycle 6, tag 8 in cycle 12.
- Overtake: DIV tag 9 in cycle 0, SUB tag 10 in cycle 1 → SUB accepted (issue_flags=0010); wb tag 10 in cycle 3, wb tag 9 in cycle 6.
- Reset mid-flight: MUL tag 4 in cycle 0, rst=1 in cycle 1 → no wb_valid in cycle 3; in_flight=0 and idle=1 from cycle 2.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared opcode, latency and writeback-slot definitions for the FPU issue path.
package fpu_pkg;
    localparam int MAX_LAT = 16;
    localparam int MAX_TAG_W = 16;
    typedef logic [1:0] fpu_op_t;
    localparam fpu_op_t OP_ADD = 2'd0;
    localparam fpu_op_t OP_SUB = 2'd1;
    localparam fpu_op_t OP_MUL = 2'd2;
    localparam fpu_op_t OP_DIV = 2'd3;
    typedef struct packed {
        logic                 valid;
        fpu_op_t              op;
        logic [MAX_TAG_W-1:0] tag;
    } wb_slot_t;
endpackage

// File: rtl/wb_reservation_table.sv
// wb_reservation_table: writeback slots indexed by (cycles-until-writeback - 1), shifting one step per cycle.
module wb_reservation_table
    import fpu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [3:0]       wr_idx,
    input  fpu_op_t          wr_op,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [3:0]       rd_idx,
    output logic             rd_free,
    output logic             wb_valid,
    output fpu_op_t          wb_op,
    output logic [TAG_W-1:0] wb_tag
);
    wb_slot_t         slot_q [MAX_LAT];
    wb_slot_t         slot_d [MAX_LAT];
    wb_slot_t         nxt [MAX_LAT];
    wb_slot_t         wr_slot;
    logic             wb_valid_q, wb_valid_d;
    fpu_op_t          wb_op_q, wb_op_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
    always_comb begin
        wr_slot = '{valid: 1'b1, op: wr_op, tag: MAX_TAG_W'(wr_tag)};
        for (int i = 0; i < MAX_LAT; i++)
            nxt[i] = (wr_en && wr_idx == 4'(i)) ? wr_slot : slot_q[i];
        for (int i = 0; i < MAX_LAT - 1; i++)
            slot_d[i] = nxt[i + 1];
        slot_d[MAX_LAT-1] = '0;
        // The entry at distance 1 (including a same-cycle write) becomes the registered writeback.
        wb_valid_d = nxt[0].valid;
        wb_op_d    = nxt[0].op;
        wb_tag_d   = nxt[0].tag[TAG_W-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LAT; i++)
                slot_q[i] <= '0;
            wb_valid_q <= 1'b0;
            wb_op_q    <= '0;
            wb_tag_q   <= '0;
        end else begin
            for (int i = 0; i < MAX_LAT; i++)
                slot_q[i] <= slot_d[i];
            wb_valid_q <= wb_valid_d;
            wb_op_q    <= wb_op_d;
            wb_tag_q   <= wb_tag_d;
        end
    end
    assign rd_free  = !slot_q[rd_idx].valid;
    assign wb_valid = wb_valid_q;
    assign wb_op    = wb_op_q;
    assign wb_tag   = wb_tag_q;
endmodule

// File: rtl/fpu_issue_scheduler.sv
// fpu_issue_scheduler: in-order FPU issue with writeback-slot reservation and divider occupancy tracking.
module fpu_issue_scheduler
    import fpu_pkg::*;
#(
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 6,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic [3:0]       issue_flags,
    output logic [TAG_W-1:0] issue_tag,
    output logic             wb_valid,
    output logic [1:0]       wb_op,
    output logic [TAG_W-1:0] wb_tag,
    output logic             div_busy,
    output logic [4:0]       in_flight,
    output logic             idle
);
    if (ADD_LAT < 1 || ADD_LAT > MAX_LAT || MUL_LAT < 1 || MUL_LAT > MAX_LAT ||
        DIV_LAT < 1 || DIV_LAT > MAX_LAT || TAG_W < 1 || TAG_W > MAX_TAG_W) begin : g_bad_param
        $error("fpu_issue_scheduler: latency must be 1..16 and TAG_W 1..16");
    end
    localparam logic [3:0] ADD_IDX = 4'(ADD_LAT - 1);
    localparam logic [3:0] MUL_IDX = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_IDX = 4'(DIV_LAT - 1);
    logic [3:0] lat_idx;
    logic       slot_free;
    logic       hs;
    logic [3:0] div_cnt_q, div_cnt_d;
    logic [4:0] in_flight_q, in_flight_d;
    always_comb begin
        lat_idx     = (in_op == OP_ADD || in_op == OP_SUB) ? ADD_IDX : (in_op == OP_MUL ? MUL_IDX : DIV_IDX);
        in_ready    = !rst && slot_free && !(in_op == OP_DIV && div_busy);
        hs          = in_valid && in_ready;
        issue_flags = hs ? 4'b0001 << in_op : 4'b0000;
        issue_tag   = hs ? in_tag : '0;
        // Busy for DIV_LAT-1 cycles after the handshake so a new DIV can start on the writeback cycle.
        div_cnt_d   = (hs && in_op == OP_DIV) ? DIV_IDX : (div_cnt_q != 4'd0 ? div_cnt_q - 4'd1 : 4'd0);
        in_flight_d = in_flight_q + 5'(hs) - 5'(wb_valid);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q   <= '0;
            in_flight_q <= '0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            in_flight_q <= in_flight_d;
        end
    end
    wb_reservation_table #(.TAG_W(TAG_W)) u_table (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (hs),
        .wr_idx   (lat_idx),
        .wr_op    (in_op),
        .wr_tag   (in_tag),
        .rd_idx   (lat_idx),
        .rd_free  (slot_free),
        .wb_valid (wb_valid),
        .wb_op    (wb_op),
        .wb_tag   (wb_tag)
    );
    assign div_busy  = div_cnt_q != 4'd0;
    assign in_flight = in_flight_q;
    assign idle      = in_flight_q == 5'd0 && !div_busy;
endmodule

// File: tb/tb_fpu_issue_scheduler.sv
// tb_fpu_issue_scheduler: directed stimulus with a cycle-stamped writeback scoreboard.
module tb_fpu_issue_scheduler;
    import fpu_pkg::*;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] in_op = 2'd0;
    logic [3:0] in_tag = 4'd0;
    logic       in_ready;
    logic [3:0] issue_flags;
    logic [3:0] issue_tag;
    logic       wb_valid;
    logic [1:0] wb_op;
    logic [3:0] wb_tag;
    logic       div_busy;
    logic [4:0] in_flight;
    logic       idle;
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int peak = 0;
    typedef struct {
        int         cyc;
        logic [1:0] op;
        logic [3:0] tag;
    } exp_t;
    exp_t sb[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    fpu_issue_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_tag      (in_tag),
        .issue_flags (issue_flags),
        .issue_tag   (issue_tag),
        .wb_valid    (wb_valid),
        .wb_op       (wb_op),
        .wb_tag      (wb_tag),
        .div_busy    (div_busy),
        .in_flight   (in_flight),
        .idle        (idle)
    );
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask
    function automatic int lat(input logic [1:0] op);
        return op == OP_DIV ? 6 : (op == OP_MUL ? 3 : 2);
    endfunction
    task automatic push(input exp_t e);
        int idx = 0;
        while (idx < sb.size() && sb[idx].cyc <= e.cyc) idx++;
        sb.insert(idx, e);
    endtask
    // Offer one op until accepted; report stalled cycles and how many of them had div_busy set.
    task automatic send(input logic [1:0] op, input logic [3:0] tag, output int stalls, output int busy);
        exp_t e;
        bit   ok = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_tag   = tag;
        stalls   = 0;
        busy     = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            stalls++;
            if (div_busy) busy++;
        end
        if (!ok) chk("send_timeout", int'(in_ready), 1);
        else begin
            chk("issue_flags", int'(issue_flags), 1 << op);
            chk("issue_tag", int'(issue_tag), int'(tag));
            e.cyc = cyc + lat(op);
            e.op  = op;
            e.tag = tag;
            push(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 2'd0;
        in_tag   = 4'd0;
    endtask
    task automatic wait_idle();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (idle && sb.size() == 0) break;
        end
        chk("drain_idle", int'(idle), 1);
        chk("drain_pending", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (in_flight > peak) peak = int'(in_flight);
        if (wb_valid) begin
            if (sb.size() == 0) chk("wb_unexpected", int'(wb_valid), 0);
            else begin
                e = sb.pop_front();
                chk("wb_tag", int'(wb_tag), int'(e.tag));
                chk("wb_op", int'(wb_op), int'(e.op));
                chk("wb_cycle", cyc, e.cyc);
            end
        end else chk("wb_zero_when_idle", int'({wb_op, wb_tag}), 0);
    end
    initial begin
        int st, bz;
        in_valid = 1'b1;
        in_op    = OP_ADD;
        in_tag   = 4'd3;
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", int'(in_ready), 0);
            chk("rst_issue_flags", int'(issue_flags), 0);
            chk("rst_wb_valid", int'(wb_valid), 0);
            chk("rst_idle", int'(idle), 1);
            chk("rst_in_flight", int'(in_flight), 0);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        peak = 0;
        send(OP_ADD, 4'd1, st, bz);
        chk("stream1_stalls", st, 0);
        send(OP_ADD, 4'd2, st, bz);
        chk("stream2_stalls", st, 0);
        send(OP_ADD, 4'd3, st, bz);
        chk("stream3_stalls", st, 0);
        wait_idle();
        chk("stream_peak_in_flight", peak, 2);
        send(OP_MUL, 4'd5, st, bz);
        send(OP_ADD, 4'd6, st, bz);
        chk("collide_stalls", st, 1);
        wait_idle();
        send(OP_DIV, 4'd7, st, bz);
        send(OP_DIV, 4'd8, st, bz);
        chk("div_stalls", st, 5);
        chk("div_busy_cycles", bz, 5);
        wait_idle();
        send(OP_DIV, 4'd9, st, bz);
        send(OP_SUB, 4'd10, st, bz);
        chk("overtake_stalls", st, 0);
        wait_idle();
        send(OP_MUL, 4'd4, st, bz);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_op    = OP_ADD;
        in_tag   = 4'd1;
        sb.delete();
        @(negedge clk);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_issue_flags", int'(issue_flags), 0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_in_flight", int'(in_flight), 0);
        chk("midrst_idle", int'(idle), 1);
        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
